// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache, 4-word lines; hits answer in the same cycle, misses stall 1+4*MEM_LAT (clean) or 1+8*MEM_LAT (dirty) cycles.
// Optional DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 28 - IB;
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TW-1:0]        tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES][4];
    logic [1:0]           word_cnt;
    logic [LW-1:0]        lat_cnt;
    logic [IB-1:0]        m_idx;
    logic [TW-1:0]        m_tag;

    logic          req, hit, miss, lat_done, fill_wr;
    logic [1:0]    off, next_word;
    logic [IB-1:0] idx;
    logic [TW-1:0] tag;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req       = cpu_rd | cpu_wr;
    assign off       = cpu_addr[3:2];
    assign idx       = cpu_addr[3+IB:4];
    assign tag       = cpu_addr[31:4+IB];
    assign hit       = rst_n && (state == IDLE) && req && valid[idx] && (tag_arr[idx] == tag);
    assign miss      = rst_n && (state == IDLE) && req && !hit;
    assign cpu_stall = rst_n && ((state != IDLE) || miss);
    assign cpu_rdata = (hit && !cpu_wr) ? data_arr[idx][off] : 32'd0;
    assign lat_done  = (lat_cnt == LW'(MEM_LAT - 1));
    assign fill_wr   = (state == FILL) && lat_done;
    assign next_word = word_cnt + 2'd1;

    // Line storage carries no reset; only valid/dirty decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (hit && cpu_wr)
                data_arr[idx][off] <= cpu_wdata;
            if (fill_wr) begin
                data_arr[m_idx][word_cnt] <= mem_rdata;
                if (word_cnt == 2'd3)
                    tag_arr[m_idx] <= m_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            word_cnt  <= 2'd0;
            lat_cnt   <= '0;
            m_idx     <= '0;
            m_tag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && cpu_wr)
                        dirty[idx] <= 1'b1;
                    if (miss) begin
                        m_idx    <= idx;
                        m_tag    <= tag;
                        word_cnt <= 2'd0;
                        lat_cnt  <= '0;
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WB;
                            mem_wr    <= 1'b1;
                            mem_addr  <= {2'b00, tag_arr[idx], idx, 2'd0};
                            mem_wdata <= data_arr[idx][0];
                        end else begin
                            state    <= FILL;
                            mem_rd   <= 1'b1;
                            mem_addr <= {2'b00, tag, idx, 2'd0};
                        end
                    end
                end
                WB: begin
                    if (!lat_done) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else begin
                        lat_cnt <= '0;
                        if (word_cnt == 2'd3) begin
                            state    <= FILL;
                            word_cnt <= 2'd0;
                            mem_wr   <= 1'b0;
                            mem_rd   <= 1'b1;
                            mem_addr <= {2'b00, m_tag, m_idx, 2'd0};
                        end else begin
                            word_cnt  <= next_word;
                            mem_addr  <= {2'b00, tag_arr[m_idx], m_idx, next_word};
                            mem_wdata <= data_arr[m_idx][next_word];
                        end
                    end
                end
                FILL: begin
                    if (!lat_done) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else begin
                        lat_cnt <= '0;
                        if (word_cnt == 2'd3) begin
                            state        <= IDLE;
                            word_cnt     <= 2'd0;
                            mem_rd       <= 1'b0;
                            valid[m_idx] <= 1'b1;
                            dirty[m_idx] <= 1'b0;
                        end else begin
                            word_cnt <= next_word;
                            mem_addr <= {2'b00, m_tag, m_idx, next_word};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit right after a fill is the stalled access retiring, already counted as a miss.
    logic after_fill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt    <= 32'd0;
            miss_cnt   <= 32'd0;
            after_fill <= 1'b0;
        end else begin
            after_fill <= fill_wr && (word_cnt == 2'd3);
            if (hit && !after_fill && (hit_cnt != 32'hFFFF_FFFF))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss && (miss_cnt != 32'hFFFF_FFFF))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a cycle-by-cycle vector table on a MEM_LAT=1 instance,
// plus hand sequences for reset during fill and a MEM_LAT=3 clean miss.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;

    logic        cpu_rd3, cpu_wr3;
    logic [31:0] cpu_addr3, cpu_wdata3, cpu_rdata3;
    logic        cpu_stall3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic        mem_rd3, mem_wr3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'd9) ? 32'hDEAD_BEEF : (32'hA000_0000 | a);
    endfunction

    // Backing memory for the MEM_LAT=1 instance; it takes write-backs.
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = init_word(32'(i));
    always @(posedge clk) if (mem_wr) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata  = mem[mem_addr[5:0]];
    assign mem_rdata3 = init_word({26'd0, mem_addr3[5:0]});

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, hit_cnt3, miss_cnt3;
`endif

    dcache_ctrl #(.NUM_LINES(8), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    dcache_ctrl #(.NUM_LINES(8), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd3), .cpu_wr(cpu_wr3),
        .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3), .cpu_rdata(cpu_rdata3),
        .cpu_stall(cpu_stall3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
        .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt3), .miss_cnt(miss_cnt3)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] rdata;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    // One vector per clock: drive just after the rising edge, check at the falling edge.
    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].stall});
            chk($sformatf("v%0d rdata", i), cpu_rdata, vecs[i].rdata);
            chk($sformatf("v%0d mem_rd", i), {31'd0, mem_rd}, {31'd0, vecs[i].mrd});
            chk($sformatf("v%0d mem_wr", i), {31'd0, mem_wr}, {31'd0, vecs[i].mwr});
            if (vecs[i].mrd || vecs[i].mwr)
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
            if (vecs[i].mwr)
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwdata);
        end
    endtask

    // Holds the current request until the stall drops, bounded.
    task automatic wait_unstall(input string name);
        int cyc;
        cyc = 0;
        while (cpu_stall && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (cpu_stall) begin
            n_fail++;
            $display("FAIL %s timeout: stall still %0b after %0d cycles, required 0", name, cpu_stall, cyc);
        end
    endtask

    initial begin
        // {rd, wr, addr, wdata, stall, rdata, mem_rd, mem_wr, mem_addr, mem_wdata}
        vecs[0]  = '{1, 0, 32'h24, 0, 1, 0, 0, 0, 0, 0};           // cold miss, index 2
        vecs[1]  = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 8, 0};
        vecs[2]  = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 9, 0};
        vecs[3]  = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 10, 0};
        vecs[4]  = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 11, 0};
        vecs[5]  = '{1, 0, 32'h24, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 32'h24, 32'h1234_5678, 0, 0, 0, 0, 0, 0}; // store hit
        vecs[7]  = '{1, 0, 32'h24, 0, 0, 32'h1234_5678, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 32'hA4, 0, 1, 0, 0, 0, 0, 0};             // conflict, dirty victim
        vecs[9]  = '{1, 0, 32'hA4, 0, 1, 0, 0, 1, 8, 32'hA000_0008};
        vecs[10] = '{1, 0, 32'hA4, 0, 1, 0, 0, 1, 9, 32'h1234_5678};
        vecs[11] = '{1, 0, 32'hA4, 0, 1, 0, 0, 1, 10, 32'hA000_000A};
        vecs[12] = '{1, 0, 32'hA4, 0, 1, 0, 0, 1, 11, 32'hA000_000B};
        vecs[13] = '{1, 0, 32'hA4, 0, 1, 0, 1, 0, 40, 0};
        vecs[14] = '{1, 0, 32'hA4, 0, 1, 0, 1, 0, 41, 0};
        vecs[15] = '{1, 0, 32'hA4, 0, 1, 0, 1, 0, 42, 0};
        vecs[16] = '{1, 0, 32'hA4, 0, 1, 0, 1, 0, 43, 0};
        vecs[17] = '{1, 0, 32'hA4, 0, 0, 32'hA000_0029, 0, 0, 0, 0};
        vecs[18] = '{0, 0, 32'h24, 0, 0, 0, 0, 0, 0, 0};             // no request: rdata 0
        vecs[19] = '{1, 0, 32'h24, 0, 1, 0, 0, 0, 0, 0};             // clean conflict back
        vecs[20] = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 8, 0};
        vecs[21] = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 9, 0};
        vecs[22] = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 10, 0};
        vecs[23] = '{1, 0, 32'h24, 0, 1, 0, 1, 0, 11, 0};
        vecs[24] = '{1, 0, 32'h24, 0, 0, 32'h1234_5678, 0, 0, 0, 0}; // written-back data returns

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h24, 32'd0);
        cpu_rd3 = 1'b0; cpu_wr3 = 1'b0; cpu_addr3 = 32'd0; cpu_wdata3 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {31'd0, cpu_stall}, 32'd0);
        chk("reset mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);

        run_vectors(0, 17);
`ifdef DCACHE_STATS_EN
        // Misses at the cold load and the eviction; hits are the store and its read-back.
        chk("stats miss_cnt", miss_cnt, 32'd2);
        chk("stats hit_cnt", hit_cnt, 32'd2);
`endif
        run_vectors(18, 24);

        // Reset during the second fill word of a miss to index 6.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h64, 32'd0);
        @(negedge clk);
        chk("rst-fill miss stall", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        chk("rst-fill word0 addr", mem_addr, 32'd24);
        @(negedge clk);
        chk("rst-fill word1 addr", mem_addr, 32'd25);
        chk("rst-fill word1 mem_rd", {31'd0, mem_rd}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst-fill stall in reset", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst-fill mem_rd after", {31'd0, mem_rd}, 32'd0);
        chk("rst-fill mem_wr after", {31'd0, mem_wr}, 32'd0);
        chk("rst-fill mem_addr after", mem_addr, 32'd0);
        chk("rst-fill re-miss stall", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        chk("rst-fill restart addr", mem_addr, 32'd24);
        wait_unstall("rst-fill refill");
        chk("rst-fill refill rdata", cpu_rdata, 32'hA000_0019);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h24, 32'd0);
        @(negedge clk);
        chk("invalidated line misses", {31'd0, cpu_stall}, 32'd1);
        wait_unstall("invalidated refill");
        chk("invalidated refill rdata", cpu_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);

        // MEM_LAT=3 clean miss: each word address held three cycles, 13-cycle stall.
        begin
            int stall_cycles;
            stall_cycles = 0;
            @(posedge clk); #1;
            cpu_rd3 = 1'b1; cpu_addr3 = 32'h24;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (!cpu_stall3) break;
                stall_cycles++;
                if (c >= 1) begin
                    chk($sformatf("lat3 c%0d mem_addr", c), mem_addr3, 32'(8 + (c - 1) / 3));
                    chk($sformatf("lat3 c%0d mem_rd", c), {31'd0, mem_rd3}, 32'd1);
                end
            end
            chk("lat3 stall cycles", 32'(stall_cycles), 32'd13);
            chk("lat3 rdata", cpu_rdata3, 32'hDEAD_BEEF);
            chk("lat3 mem_rd idle", {31'd0, mem_rd3}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
